// File: rtl/fv_ldst_agu_if.sv
// Bundle of the decode-side request, DMEM request, issue trace and drop-report
// signals of the load/store address-generation stage.
interface fv_ldst_agu_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int IMM_WIDTH  = 12
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_is_store;
  logic [1:0]            in_size;
  logic [31:0]           in_base;
  logic [IMM_WIDTH-1:0]  in_imm;
  logic [31:0]           in_wdata;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [3:0]            mem_req_be;
  logic [31:0]           mem_req_wdata;
  logic                  ld_st_valid;
  logic [ADDR_WIDTH-1:0] ld_st_effaddr;
  logic [31:0]           ld_st_imm;
  logic                  err_valid;
  logic                  err_misalign;
  logic [31:0]           err_addr;

  modport master (
    output in_valid, in_is_store, in_size, in_base, in_imm, in_wdata, mem_req_ready,
    input  in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
    input  ld_st_valid, ld_st_effaddr, ld_st_imm, err_valid, err_misalign, err_addr
  );

  modport slave (
    input  in_valid, in_is_store, in_size, in_base, in_imm, in_wdata, mem_req_ready,
    output in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
    output ld_st_valid, ld_st_effaddr, ld_st_imm, err_valid, err_misalign, err_addr
  );
endinterface

// File: rtl/fv_ldst_agu.sv
// Load/store AGU: effaddr = base + sext(imm), drops misaligned/out-of-range ops
// with a one-cycle error pulse, and queues legal ops in a 2-entry skid queue.
module fv_ldst_agu #(
  parameter int ADDR_WIDTH = 16,
  parameter int DMEM_SIZE  = 1024,
  parameter int IMM_WIDTH  = 12
) (
  input  logic          clk,
  input  logic          rst,
  fv_ldst_agu_if.slave  bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [31:0]           imm;
  } entry_t;

  localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_SIZE);

  state_t      state_reg;
  entry_t      head_reg, tail_reg, new_entry;
  logic        err_valid_reg, err_misalign_reg;
  logic [31:0] err_addr_reg;

  logic [31:0] imm_sext, sum, lane_wdata;
  logic [3:0]  be_next;
  logic        is_half, is_word, misalign, out_of_range;
  logic        accept, drop, legal, issue;

  assign imm_sext     = {{(32-IMM_WIDTH){bus.in_imm[IMM_WIDTH-1]}}, bus.in_imm};
  assign sum          = bus.in_base + imm_sext;
  assign is_half      = (bus.in_size == 2'd1);
  assign is_word      = bus.in_size[1];
  assign misalign     = (is_half & sum[0]) | (is_word & (|sum[1:0]));
  // Full 32-bit compare so any set bit above the DMEM window counts as out of range.
  assign out_of_range = (sum >= DMEM_LIMIT);
  assign accept       = bus.in_valid & bus.in_ready;
  assign drop         = accept & (misalign | out_of_range);
  assign legal        = accept & ~misalign & ~out_of_range;
  assign issue        = (state_reg != EMPTY) & bus.mem_req_ready;

  always_comb begin
    be_next = 4'b1111;
    if (is_half)
      be_next = 4'b0011 << {sum[1], 1'b0};
    else if (!is_word)
      be_next = 4'b0001 << sum[1:0];
  end

  // Store data replicated so each enabled byte lane carries the right byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_wdata[8*gi +: 8] = is_word ? bus.in_wdata[8*gi +: 8] :
                                   is_half ? bus.in_wdata[8*(gi%2) +: 8] :
                                             bus.in_wdata[7:0];
  end

  always_comb begin
    new_entry       = '0;
    new_entry.we    = bus.in_is_store;
    new_entry.addr  = sum[ADDR_WIDTH-1:0];
    new_entry.be    = be_next;
    new_entry.wdata = bus.in_is_store ? lane_wdata : 32'd0;
    new_entry.imm   = imm_sext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= EMPTY;
      head_reg         <= '0;
      tail_reg         <= '0;
      err_valid_reg    <= 1'b0;
      err_misalign_reg <= 1'b0;
      err_addr_reg     <= '0;
    end else begin
      err_valid_reg    <= drop;
      err_misalign_reg <= drop & misalign;
      if (drop)
        err_addr_reg <= sum;
      case (state_reg)
        EMPTY: begin
          if (legal) begin
            head_reg  <= new_entry;
            state_reg <= ONE;
          end
        end
        ONE: begin
          if (legal && !issue) begin
            tail_reg  <= new_entry;
            state_reg <= TWO;
          end else if (legal && issue) begin
            head_reg  <= new_entry;
          end else if (issue) begin
            state_reg <= EMPTY;
          end
        end
        TWO: begin
          if (issue) begin
            head_reg  <= tail_reg;
            state_reg <= ONE;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

  assign bus.in_ready      = (state_reg != TWO);
  assign bus.mem_req_valid = (state_reg != EMPTY);
  assign bus.mem_req_we    = head_reg.we;
  assign bus.mem_req_addr  = head_reg.addr;
  assign bus.mem_req_be    = head_reg.be;
  assign bus.mem_req_wdata = head_reg.wdata;
  assign bus.ld_st_valid   = bus.mem_req_valid & bus.mem_req_ready;
  assign bus.ld_st_effaddr = head_reg.addr;
  assign bus.ld_st_imm     = head_reg.imm;
  assign bus.err_valid     = err_valid_reg;
  assign bus.err_misalign  = err_misalign_reg;
  assign bus.err_addr      = err_addr_reg;
endmodule
